unified_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage load/store port.
- Fixed priority: data requests win over instruction requests. A starvation limit guarantees fetch progress.
- Exactly one memory transaction is outstanding at a time.
- Produces the stall signals that the hazard unit ORs into StallF and into the MEM-stage hold.

---
 rtl/arb_pkg.sv | 13 +
 rtl/arb_starve_ctr.sv | 40 ++++
 rtl/unified_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default parameter values for the unified memory arbiter.
package arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
   typedef enum logic {INSTR, DATA} owner_t;

   localparam int ARB_ADDR_W       = 32;
   localparam int ARB_DATA_W       = 32;
   localparam int ARB_STARVE_LIMIT = 4;
   // Wide enough for the largest legal STARVE_LIMIT (15).
   localparam int STREAK_W         = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Winner selection between fetch and load/store, plus the saturating streak
// counter that bounds how long a pending fetch can be starved by data traffic.
module arb_starve_ctr
   import arb_pkg::*;
#(
   parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
   input  logic clk,
   input  logic reset,
   input  logic arb_en,
   input  logic instr_req,
   input  logic data_req,
   output logic grant_data,
   output logic grant_instr,
   output logic forced
);

   localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

   logic [STREAK_W-1:0] streak;
   logic                at_limit;

   assign at_limit    = (streak == LIMIT);
   assign grant_data  = arb_en && data_req && !(instr_req && at_limit);
   assign grant_instr = arb_en && instr_req && !grant_data;
   assign forced      = arb_en && instr_req && data_req && at_limit;

   always_ff @(posedge clk) begin
      if (!reset) begin
         streak <= '0;
      end else if (arb_en) begin
         if (!instr_req || grant_instr) begin
            streak <= '0;
         end else if (grant_data && !at_limit) begin
            streak <= streak + 1'b1;
         end
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Optional performance counters are enabled with UNIFIED_MEM_ARB_PERF_EN.
module unified_mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W       = ARB_ADDR_W,
   parameter int DATA_W       = ARB_DATA_W,
   parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
`ifdef UNIFIED_MEM_ARB_PERF_EN
   ,
   parameter int CNT_W        = 32
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                instr_req,
   input  logic [ADDR_W-1:0]   instr_addr,
   output logic [DATA_W-1:0]   instr_rdata,
   output logic                instr_valid,
   input  logic                data_req,
   input  logic                data_we,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   input  logic [DATA_W/8-1:0] data_be,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                data_done,
   output logic                stall_if,
   output logic                stall_mem,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
`ifdef UNIFIED_MEM_ARB_PERF_EN
   ,
   output logic [CNT_W-1:0]    perf_if_stall,
   output logic [CNT_W-1:0]    perf_mem_stall,
   output logic [CNT_W-1:0]    perf_starve
`endif
);

   arb_state_t state;
   owner_t     owner;
   logic       arb_idle;
   logic       grant_data;
   logic       grant_instr;
   logic       forced;
   logic       owner_req;
   logic       rsp_ok;
   logic       store_ack;

   assign arb_idle = (state == IDLE);

   arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk         (clk),
      .reset       (reset),
      .arb_en      (arb_idle),
      .instr_req   (instr_req),
      .data_req    (data_req),
      .grant_data  (grant_data),
      .grant_instr (grant_instr),
      .forced      (forced)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= INSTR;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_data) begin
                  owner     <= DATA;
                  mem_we    <= data_we;
                  mem_addr  <= data_addr;
                  mem_wdata <= data_wdata;
                  mem_be    <= data_be;
                  state     <= ISSUE;
               end else if (grant_instr) begin
                  owner     <= INSTR;
                  mem_we    <= 1'b0;
                  mem_addr  <= instr_addr;
                  mem_wdata <= '0;
                  mem_be    <= '1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_gnt) begin
                  state <= mem_we ? IDLE : WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A response whose requester has dropped its request (flush) is discarded.
   assign owner_req = (owner == DATA) ? data_req : instr_req;
   assign rsp_ok    = reset && (state == WAIT) && mem_rvalid && owner_req;
   assign store_ack = reset && (state == ISSUE) && mem_gnt && mem_we;

   assign mem_req     = reset && (state == ISSUE);
   assign instr_valid = rsp_ok && (owner == INSTR);
   assign data_done   = (rsp_ok && (owner == DATA)) || store_ack;
   assign instr_rdata = mem_rdata;
   assign data_rdata  = mem_rdata;
   assign stall_if    = instr_req && !instr_valid;
   assign stall_mem   = data_req && !data_done;

`ifdef UNIFIED_MEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_if_stall  <= '0;
         perf_mem_stall <= '0;
         perf_starve    <= '0;
      end else begin
         perf_if_stall  <= perf_if_stall + CNT_W'(stall_if);
         perf_mem_stall <= perf_mem_stall + CNT_W'(stall_mem);
         perf_starve    <= perf_starve + CNT_W'(forced);
      end
   end
`endif

   a_gnt_rvalid: assert property (@(posedge clk) disable iff (!reset)
      !((state == ISSUE) && mem_gnt && mem_rvalid))
      else $error("mem_gnt and mem_rvalid asserted together while issuing");

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a cycle table for basic fetch/store
// traffic plus hand-written sequences for starvation, stalls, flush and reset.
module tb_unified_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic [31:0] instr_rdata;
   logic        instr_valid;
   logic        data_req;
   logic        data_we;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_be;
   logic [31:0] data_rdata;
   logic        data_done;
   logic        stall_if;
   logic        stall_mem;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
`ifdef UNIFIED_MEM_ARB_PERF_EN
   logic [31:0] perf_if_stall;
   logic [31:0] perf_mem_stall;
   logic [31:0] perf_starve;
`endif

   int checks = 0;
   int errors = 0;

   int stall_left = 0;
   int rv_extra   = 0;
   int rv_count   = 0;
   logic [31:0] rd_addr;

   unified_mem_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .instr_req   (instr_req),
      .instr_addr  (instr_addr),
      .instr_rdata (instr_rdata),
      .instr_valid (instr_valid),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_be     (data_be),
      .data_rdata  (data_rdata),
      .data_done   (data_done),
      .stall_if    (stall_if),
      .stall_mem   (stall_mem),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata)
`ifdef UNIFIED_MEM_ARB_PERF_EN
      ,
      .perf_if_stall  (perf_if_stall),
      .perf_mem_stall (perf_mem_stall),
      .perf_starve    (perf_starve)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0050_0093 : (a + 32'h1000_0000);
   endfunction

   // Memory model: grant after stall_left refused cycles, read data
   // rv_extra cycles after the minimum one-cycle gap.
   initial begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      rd_addr    = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         if (rv_count > 0) begin
            rv_count--;
            if (rv_count == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem_word(rd_addr);
            end
         end
         if (mem_req) begin
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               mem_gnt = 1'b1;
               if (!mem_we) begin
                  rv_count = 1 + rv_extra;
                  rd_addr  = mem_addr;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic to_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [3:0]  dbe;
      logic        mreq;
      logic        mwe;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [3:0]  mbe;
      logic        ivld;
      logic        ddone;
      logic        sif;
      logic        smem;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[10];
   logic grant_is_data[6];
   int   ngr;
   logic seen;

   initial begin
      // fetch at 0x0, then a store racing a fetch to 0x10
      vecs[0] = '{1'b1, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'h0,   32'h0,        4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[2] = '{1'b1, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0050_0093};
      vecs[3] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[4] = '{1'b1, 32'h10, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
      vecs[5] = '{1'b1, 32'h10, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[6] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[7] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[8] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0010};
      vecs[9] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

      reset      = 1'b0;
      instr_req  = 1'b0;
      instr_addr = 32'h0;
      data_req   = 1'b0;
      data_we    = 1'b0;
      data_addr  = 32'h0;
      data_wdata = 32'h0;
      data_be    = 4'h0;

      repeat (3) to_cycle();
      @(negedge clk);
      chk("reset_mem_req", 32'(mem_req), 32'h0);
      chk("reset_mem_we", 32'(mem_we), 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_be", 32'(mem_be), 32'h0);
      chk("reset_instr_valid", 32'(instr_valid), 32'h0);
      chk("reset_data_done", 32'(data_done), 32'h0);

      for (int i = 0; i < 10; i++) begin
         to_cycle();
         reset      = 1'b1;
         instr_req  = vecs[i].ireq;
         instr_addr = vecs[i].iaddr;
         data_req   = vecs[i].dreq;
         data_we    = vecs[i].dwe;
         data_addr  = vecs[i].daddr;
         data_wdata = vecs[i].dwdata;
         data_be    = vecs[i].dbe;
         @(negedge clk);
         chk($sformatf("vec%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].mreq));
         chk($sformatf("vec%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].ivld));
         chk($sformatf("vec%0d_data_done", i), 32'(data_done), 32'(vecs[i].ddone));
         chk($sformatf("vec%0d_stall_if", i), 32'(stall_if), 32'(vecs[i].sif));
         chk($sformatf("vec%0d_stall_mem", i), 32'(stall_mem), 32'(vecs[i].smem));
         if (vecs[i].mreq) begin
            chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].mwe));
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].maddr);
            chk($sformatf("vec%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].mbe));
            if (vecs[i].mwe) chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].mwdata);
         end
         if (vecs[i].ivld) chk($sformatf("vec%0d_instr_rdata", i), instr_rdata, vecs[i].rdata);
      end

      // Starvation: continuous loads against a pending fetch.
      to_cycle();
      instr_req  = 1'b1;
      instr_addr = 32'h20;
      data_req   = 1'b1;
      data_we    = 1'b0;
      data_addr  = 32'h200;
      data_be    = 4'hF;
      ngr = 0;
      for (int c = 0; c < 60 && ngr < 6; c++) begin
         @(negedge clk);
         if (mem_req && mem_gnt) begin
            grant_is_data[ngr] = (mem_addr == 32'h200);
            ngr++;
         end
         if (ngr < 6) to_cycle();
      end
      chk("starve_grant_count", 32'(ngr), 32'd6);
      for (int g = 0; g < 6; g++) begin
         if (g < ngr) chk($sformatf("starve_grant%0d_is_data", g), 32'(grant_is_data[g]), (g == 4) ? 32'h0 : 32'h1);
      end
`ifdef UNIFIED_MEM_ARB_PERF_EN
      chk("perf_starve", perf_starve, 32'h1);
`endif
      to_cycle();
      instr_req = 1'b0;
      data_req  = 1'b0;
      repeat (4) to_cycle();

      // Memory refuses the grant for three cycles on a store.
      stall_left = 3;
      data_req   = 1'b1;
      data_we    = 1'b1;
      data_addr  = 32'h300;
      data_wdata = 32'h1234_5678;
      data_be    = 4'hC;
      for (int c = 1; c <= 4; c++) begin
         to_cycle();
         @(negedge clk);
         chk($sformatf("gstall%0d_mem_req", c), 32'(mem_req), 32'h1);
         chk($sformatf("gstall%0d_mem_addr", c), mem_addr, 32'h300);
         chk($sformatf("gstall%0d_mem_wdata", c), mem_wdata, 32'h1234_5678);
         chk($sformatf("gstall%0d_mem_be", c), 32'(mem_be), 32'hC);
         chk($sformatf("gstall%0d_data_done", c), 32'(data_done), (c == 4) ? 32'h1 : 32'h0);
         chk($sformatf("gstall%0d_stall_mem", c), 32'(stall_mem), (c == 4) ? 32'h0 : 32'h1);
      end
      to_cycle();
      data_req = 1'b0;
      data_we  = 1'b0;
      @(negedge clk);
      chk("gstall_after_mem_req", 32'(mem_req), 32'h0);

      // Fetch flushed while waiting for read data.
      to_cycle();
      rv_extra   = 2;
      instr_req  = 1'b1;
      instr_addr = 32'h40;
      to_cycle();
      to_cycle();
      @(negedge clk);
      chk("flush_wait_instr_valid", 32'(instr_valid), 32'h0);
      chk("flush_wait_stall_if", 32'(stall_if), 32'h1);
      to_cycle();
      instr_req = 1'b0;
      @(negedge clk);
      chk("flush_drop_instr_valid", 32'(instr_valid), 32'h0);
      to_cycle();
      @(negedge clk);
      chk("flush_rvalid_instr_valid", 32'(instr_valid), 32'h0);
      chk("flush_rvalid_data_done", 32'(data_done), 32'h0);
      to_cycle();
      rv_extra   = 0;
      instr_req  = 1'b1;
      instr_addr = 32'h44;
      @(negedge clk);
      chk("flush_idle_mem_req", 32'(mem_req), 32'h0);
      to_cycle();
      @(negedge clk);
      chk("flush_next_mem_req", 32'(mem_req), 32'h1);
      chk("flush_next_mem_addr", mem_addr, 32'h44);
      to_cycle();
      @(negedge clk);
      chk("flush_next_instr_valid", 32'(instr_valid), 32'h1);
      chk("flush_next_instr_rdata", instr_rdata, 32'h1000_0044);
      to_cycle();
      instr_req = 1'b0;

      // Reset while waiting for read data; the late rvalid must be ignored.
      to_cycle();
      rv_extra   = 1;
      instr_req  = 1'b1;
      instr_addr = 32'h50;
      to_cycle();
      to_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_wait_instr_valid", 32'(instr_valid), 32'h0);
      to_cycle();
      @(negedge clk);
      chk("rst_late_instr_valid", 32'(instr_valid), 32'h0);
      chk("rst_late_data_done", 32'(data_done), 32'h0);
      chk("rst_late_mem_req", 32'(mem_req), 32'h0);
      chk("rst_late_mem_we", 32'(mem_we), 32'h0);
      chk("rst_late_mem_addr", mem_addr, 32'h0);
      chk("rst_late_mem_wdata", mem_wdata, 32'h0);
      chk("rst_late_mem_be", 32'(mem_be), 32'h0);
      to_cycle();
      rv_extra = 0;
      reset    = 1'b1;
      @(negedge clk);
      chk("rst_release_instr_valid", 32'(instr_valid), 32'h0);
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         to_cycle();
         @(negedge clk);
         if (instr_valid) begin
            seen = 1'b1;
            chk("rst_after_instr_rdata", instr_rdata, 32'h1000_0050);
         end
      end
      chk("rst_after_fetch_done", 32'(seen), 32'h1);
      to_cycle();
      instr_req = 1'b0;
      repeat (2) to_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
